// File: rtl/rr_mux_n.sv
// rr_mux_n: N-way, WIDTH-bit registered multiplexer with valid/ready handshake.
// Purpose: forward at most one word per cycle from N producer channels to one
//    consumer. Arbitration is either an explicit select (mode=0) or round-robin (mode=1).
// Ports:
//    clock, reset      - single clock, synchronous active-high reset
//    in_data           - N packed channels, channel i at [i*WIDTH +: WIDTH]
//    in_valid/in_ready - per-channel handshake (in_ready is combinational)
//    mode, sel         - arbitration mode and explicit channel select
//    out_data/out_chan - registered word and its source channel
//    out_valid/out_ready - output handshake
module rr_mux_n #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned N     = 4,
   localparam int unsigned SELW = $clog2(N)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_chan,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic [SELW-1:0]  ptr;
   logic [SELW-1:0]  gnt;
   logic             gnt_valid;
   logic             load_en;
   logic             xfer;
   logic [WIDTH-1:0] gnt_data;
   logic [SELW-1:0]  ptr_next;

   // Output register may load when empty or being drained this cycle.
   assign load_en = !out_valid || out_ready;
   assign xfer    = load_en && gnt_valid;

   // Grant selection. Values of sel >= N match no channel, so they grant nothing.
   always_comb begin
      logic [SELW-1:0] cs;
      int unsigned     c;
      gnt       = '0;
      gnt_valid = 1'b0;
      cs        = '0;
      c         = 0;
      if (!mode) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
               gnt       = SELW'(i);
               gnt_valid = 1'b1;
            end
         end
      end else begin
         // Scan ptr, ptr+1, ... modulo N; the first valid channel wins.
         for (int unsigned k = 0; k < N; k++) begin
            c  = (32'(ptr) + k) % N;
            cs = SELW'(c);
            if (!gnt_valid && in_valid[cs]) begin
               gnt       = cs;
               gnt_valid = 1'b1;
            end
         end
      end
   end

   // Ready depends only on handshake/select inputs, never on data.
   always_comb begin
      in_ready = '0;
      for (int unsigned i = 0; i < N; i++) begin
         in_ready[i] = xfer && (gnt == SELW'(i));
      end
   end

   always_comb begin
      gnt_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (gnt == SELW'(i)) begin
            gnt_data = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Explicit wrap so ptr never reaches N when N is not a power of two.
   assign ptr_next = (gnt == SELW'(N - 1)) ? '0 : gnt + 1'b1;

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ptr       <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= gnt_data;
         out_chan  <= gnt;
         if (mode) begin
            ptr <= ptr_next;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
